// File: rtl/imem_loader_if.sv
// Byte-stream, control and instruction-memory write-port bundle for imem_loader.
// The slave side is the loader; the master side is the boot/debug source plus memory/core.
interface imem_loader_if #(
  parameter int CNT_W = 6
);
  logic             start;
  logic [CNT_W-1:0] num_words;
  logic             abort;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic [31:0]      mem_waddr;
  logic [31:0]      mem_wdata;
  logic             mem_we;
  logic             cpu_stall;
  logic             busy;
  logic             done;
  logic             error;

  modport master (
    output start, num_words, abort, byte_valid, byte_data,
    input  byte_ready, mem_waddr, mem_wdata, mem_we, cpu_stall, busy, done, error
  );

  modport slave (
    input  start, num_words, abort, byte_valid, byte_data,
    output byte_ready, mem_waddr, mem_wdata, mem_we, cpu_stall, busy, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a little-endian byte stream into 32-bit words,
// writes them to consecutive word addresses and stalls the core while loading.
//
// state   | meaning
// IDLE    | waiting for start; core runs
// COLLECT | accepting bytes into lanes 0..3 of the current word
// WRITE   | one-cycle memory write of the packed word
// FINISH  | one-cycle done pulse, then back to IDLE
module imem_loader #(
  parameter int          DEPTH     = 32,
  parameter logic [31:0] LOAD_BASE = 32'd0,
  parameter int          CNT_W     = 6
) (
  input  logic         clock,
  input  logic         reset_n,
  imem_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FINISH} state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t           state, state_nx;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] word_idx;
  logic [1:0]       byte_lane;
  logic [23:0]      shreg;
  logic             byte_take;
  logic             start_ok;
  logic             start_bad;
  logic             last_word;
  logic             busy_q, ready_q, we_q, done_q, error_q;
  logic [31:0]      waddr_q, wdata_q;

  always_comb begin
    state_nx  = state;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    byte_take = 1'b0;
    last_word = (word_idx + CNT_W'(1)) == count;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.num_words > DEPTH_C) begin
            start_bad = 1'b1;
          end else if (bus.num_words == '0) begin
            state_nx = FINISH;
          end else begin
            start_ok = 1'b1;
            state_nx = COLLECT;
          end
        end
      end
      COLLECT: begin
        // abort wins over a byte offered in the same cycle; that byte is dropped
        if (bus.abort) begin
          state_nx = IDLE;
        end else if (bus.byte_valid) begin
          byte_take = 1'b1;
          if (byte_lane == 2'd3) state_nx = WRITE;
        end
      end
      WRITE: begin
        if (bus.abort)      state_nx = IDLE;
        else if (last_word) state_nx = FINISH;
        else                state_nx = COLLECT;
      end
      FINISH: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= '0;
      word_idx  <= '0;
      byte_lane <= '0;
      shreg     <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state   <= state_nx;
      busy_q  <= state_nx != IDLE;
      ready_q <= state_nx == COLLECT;
      we_q    <= state_nx == WRITE;
      done_q  <= state_nx == FINISH;
      error_q <= start_bad;
      if (start_ok) begin
        count     <= bus.num_words;
        word_idx  <= '0;
        byte_lane <= '0;
      end
      if (byte_take) begin
        byte_lane <= byte_lane + 2'd1;
        case (byte_lane)
          2'd0: shreg[7:0]   <= bus.byte_data;
          2'd1: shreg[15:8]  <= bus.byte_data;
          2'd2: shreg[23:16] <= bus.byte_data;
          default: begin
            // write-port registers change only when a word completes
            waddr_q <= LOAD_BASE + 32'(word_idx);
            wdata_q <= {bus.byte_data, shreg};
          end
        endcase
      end
      if (state == WRITE && state_nx == COLLECT) word_idx <= word_idx + CNT_W'(1);
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.mem_waddr  = waddr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_we     = we_q;
  assign bus.cpu_stall  = busy_q;
  assign bus.busy       = busy_q;
  // an abort during FINISH suppresses the done pulse
  assign bus.done       = done_q & ~bus.abort;
  assign bus.error      = error_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard and a memory image model.
module tb_imem_loader;
  localparam int          CNT_W     = 6;
  localparam logic [31:0] LOAD_BASE = 32'd0;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  imem_loader_if #(.CNT_W(CNT_W)) bus ();

  imem_loader #(.DEPTH(32), .LOAD_BASE(LOAD_BASE), .CNT_W(CNT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_chk = 0;
  int n_pass = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  time we_t[$];
  time acc_t[$];
  time done_t = 0;
  logic [31:0] mem_model [0:31];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [7:0]  pat_q[$];
  logic [7:0]  tx_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference words from the byte pattern: first byte is the least significant.
  task automatic expect_words(input int nw);
    for (int w = 0; w < nw; w++) begin
      exp_addr.push_back(LOAD_BASE + 32'(w));
      exp_data.push_back(32'(pat_q[4*w]) + (32'(pat_q[4*w+1]) << 8) +
                         (32'(pat_q[4*w+2]) << 16) + (32'(pat_q[4*w+3]) << 24));
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.mem_we) begin
        we_cnt++;
        we_t.push_back($time);
        mem_model[bus.mem_waddr[4:0]] = bus.mem_wdata;
        if (exp_addr.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_write: addr %h data %h, no write required", bus.mem_waddr, bus.mem_wdata);
        end else begin
          check("waddr", bus.mem_waddr, exp_addr.pop_front());
          check("wdata", bus.mem_wdata, exp_data.pop_front());
        end
      end
      if (bus.done) begin
        done_cnt++;
        done_t = $time;
        check("stall_with_done", 32'(bus.cpu_stall), 32'd1);
      end
      if (bus.error) begin
        err_cnt++;
        check("idle_with_error", 32'(bus.busy), 32'd0);
      end
      if (bus.byte_ready) check("stall_with_ready", 32'(bus.cpu_stall), 32'd1);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
    check({tag, "_mem_waddr"},  bus.mem_waddr,        32'd0);
    check({tag, "_mem_wdata"},  bus.mem_wdata,        32'd0);
    check({tag, "_mem_we"},     32'(bus.mem_we),      32'd0);
    check({tag, "_cpu_stall"},  32'(bus.cpu_stall),   32'd0);
    check({tag, "_busy"},       32'(bus.busy),        32'd0);
    check({tag, "_done"},       32'(bus.done),        32'd0);
    check({tag, "_error"},      32'(bus.error),       32'd0);
  endtask

  task automatic start_load(input int n);
    bus.start     = 1'b1;
    bus.num_words = CNT_W'(n);
    @(posedge clock); #1;
    bus.start     = 1'b0;
    bus.num_words = '0;
  endtask

  task automatic stream(input bit gaps);
    int cyc = 0;
    bit tog = 1'b1;
    acc_t.delete();
    while (tx_q.size() > 0 && cyc < 400) begin
      bus.byte_valid = gaps ? tog : 1'b1;
      bus.byte_data  = tx_q[0];
      tog = !tog;
      @(negedge clock);
      if (bus.byte_valid && bus.byte_ready) begin
        acc_t.push_back($time);
        void'(tx_q.pop_front());
      end
      @(posedge clock); #1;
      cyc++;
    end
    bus.byte_valid = 1'b0;
    if (tx_q.size() > 0) begin
      n_chk++;
      $display("FAIL stream_timeout: %0d bytes not accepted", tx_q.size());
      tx_q.delete();
    end
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clock);
      n++;
    end
    #1;
    if (done_cnt == d0) begin
      n_chk++;
      $display("FAIL %s: no done within %0d cycles", name, budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, w0, e0;
    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.num_words  = '0;
    bus.abort      = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    for (int i = 0; i < 32; i++) mem_model[i] = '0;
    #2;
    check_all_zero("reset");
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // back-to-back two-word load
    pat_q = '{8'hB3, 8'h00, 8'hA2, 8'h00, 8'h33, 8'h01, 8'h12, 8'h40};
    expect_words(2);
    d0 = done_cnt; w0 = we_cnt;
    start_load(2);
    check("t1_stall_after_start", 32'(bus.cpu_stall), 32'd1);
    check("t1_busy_after_start", 32'(bus.busy), 32'd1);
    tx_q = pat_q;
    stream(1'b0);
    wait_done(d0, 20, "t1_done_wait");
    check("t1_stall_after_done", 32'(bus.cpu_stall), 32'd0);
    check("t1_busy_after_done", 32'(bus.busy), 32'd0);
    check("t1_writes", 32'(we_cnt - w0), 32'd2);
    check("t1_write_latency", 32'(we_t[w0] - acc_t[3]), 32'd10);
    check("t1_done_after_write", 32'(done_t - we_t[w0+1]), 32'd10);
    check("t1_mem0", mem_model[0], 32'h00A200B3);
    check("t1_mem1", mem_model[1], 32'h40120133);
    repeat (3) @(posedge clock); #1;
    check("t1_done_count", 32'(done_cnt - d0), 32'd1);

    // same load with byte_valid toggling
    for (int i = 0; i < 32; i++) mem_model[i] = '0;
    expect_words(2);
    d0 = done_cnt; w0 = we_cnt;
    start_load(2);
    tx_q = pat_q;
    stream(1'b1);
    wait_done(d0, 20, "t2_done_wait");
    check("t2_writes", 32'(we_cnt - w0), 32'd2);
    check("t2_mem0", mem_model[0], 32'h00A200B3);
    check("t2_mem1", mem_model[1], 32'h40120133);
    check("t2_scoreboard_empty", 32'(exp_addr.size()), 32'd0);

    // oversize request rejected, zero-length request completes
    d0 = done_cnt; w0 = we_cnt; e0 = err_cnt;
    start_load(33);
    check("t3_error_pulse", 32'(bus.error), 32'd1);
    check("t3_busy_on_error", 32'(bus.busy), 32'd0);
    @(posedge clock); #1;
    check("t3_error_one_cycle", 32'(bus.error), 32'd0);
    repeat (3) @(posedge clock); #1;
    check("t3_error_count", 32'(err_cnt - e0), 32'd1);
    check("t3_no_write", 32'(we_cnt - w0), 32'd0);
    start_load(0);
    check("t3_zero_done", 32'(bus.done), 32'd1);
    repeat (3) @(posedge clock); #1;
    check("t3_zero_done_count", 32'(done_cnt - d0), 32'd1);
    check("t3_zero_no_write", 32'(we_cnt - w0), 32'd0);
    check("t3_zero_idle", 32'(bus.busy), 32'd0);

    // abort after the sixth byte of a three-word load
    pat_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    expect_words(1);
    d0 = done_cnt; w0 = we_cnt;
    start_load(3);
    tx_q = pat_q;
    stream(1'b0);
    bus.abort = 1'b1;
    @(posedge clock); #1;
    bus.abort = 1'b0;
    check("t4_idle_after_abort", 32'(bus.busy), 32'd0);
    repeat (4) @(posedge clock); #1;
    check("t4_abort_writes", 32'(we_cnt - w0), 32'd1);
    check("t4_abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("t4_abort_mem0", mem_model[0], 32'hDDCCBBAA);
    pat_q = '{8'h78, 8'h56, 8'h34, 8'h12};
    expect_words(1);
    d0 = done_cnt; w0 = we_cnt;
    start_load(1);
    tx_q = pat_q;
    stream(1'b0);
    wait_done(d0, 20, "t4_reload_done_wait");
    check("t4_reload_writes", 32'(we_cnt - w0), 32'd1);
    check("t4_reload_mem0", mem_model[0], 32'h12345678);

    // asynchronous reset mid-COLLECT
    d0 = done_cnt; w0 = we_cnt;
    start_load(1);
    tx_q = '{8'h99, 8'h88};
    stream(1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("t5_reset_no_done", 32'(done_cnt - d0), 32'd0);
    check("t5_reset_no_write", 32'(we_cnt - w0), 32'd0);
    pat_q = '{8'h13, 8'h05, 8'h10, 8'h00};
    expect_words(1);
    d0 = done_cnt;
    start_load(1);
    tx_q = pat_q;
    stream(1'b0);
    wait_done(d0, 20, "t5_done_wait");
    check("t5_mem0", mem_model[0], 32'h00100513);

    // start pulsed while busy is ignored
    pat_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    expect_words(2);
    d0 = done_cnt; w0 = we_cnt; e0 = err_cnt;
    start_load(2);
    tx_q = pat_q[0:2];
    stream(1'b0);
    start_load(5);
    check("t6_still_busy", 32'(bus.busy), 32'd1);
    tx_q = pat_q[3:7];
    stream(1'b0);
    wait_done(d0, 20, "t6_done_wait");
    repeat (3) @(posedge clock); #1;
    check("t6_writes", 32'(we_cnt - w0), 32'd2);
    check("t6_done_count", 32'(done_cnt - d0), 32'd1);
    check("t6_no_error", 32'(err_cnt - e0), 32'd0);
    check("t6_mem0", mem_model[0], 32'h04030201);
    check("t6_mem1", mem_model[1], 32'h08070605);
    check("final_scoreboard_empty", 32'(exp_addr.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
